fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Next-generation single-clock synchronous FIFO. It generalises the team's 16x8 FIFO to any width and depth, including non-power-of-two depths. It adds programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, a synchronous flush and an occupancy count. It sits between a producer and a consumer in the same clock domain and keeps the existing wr_ack/overflow/underflow status semantics.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1).
FIFO_DEPTH, 8, number of storage entries (>=2, need not be a power of two).
AF_LEVEL, FIFO_DEPTH-1, almostfull asserts when count >= AF_LEVEL (legal range 1..FIFO_DEPTH-1).
AE_LEVEL, 1, almostempty asserts when 0 < count <= AE_LEVEL (legal range 1..FIFO_DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
data_in  input  FIFO_WIDTH  write data.
wr_en  input  1  write request.
rd_en  input  1  read request.
flush  input  1  synchronous clear of contents.
data_out  output  FIFO_WIDTH  read data.
rd_valid  output  1  data_out holds valid read data.
wr_ack  output  1  registered; previous-cycle write was accepted.
overflow  output  1  registered; previous-cycle write was rejected because the FIFO was full.
underflow  output  1  registered; previous-cycle read was rejected because the FIFO was empty.
full  output  1  count == FIFO_DEPTH.
empty  output  1  count == 0.
almostfull  output  1  AF_LEVEL <= count < FIFO_DEPTH.
almostempty  output  1  0 < count <= AE_LEVEL.
count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr and count = 0; data_out = 0. wr_ack, overflow, underflow = 0. rd_valid = 0 when FWFT=0. Flags: empty=1, full=0, almostfull=0, almostempty=0. Memory contents are not cleared.
- Flags and count are decoded combinationally from the count register, so they reflect state after the last clock edge.
- Write accept condition: wr_en && (!full || rd_accept). On accept: mem[wr_ptr] <= data_in, wr_ptr advances, wr_ack=1 next cycle. On reject: overflow=1 next cycle, wr_ack=0.
- Read accept condition: rd_en && !empty. On reject: underflow=1 next cycle, no state change.
  - Simultaneous read and write when empty: the write is accepted and the read gets underflow; there is no bypass.
  - Simultaneous read and write when full: both are accepted, count is unchanged and no overflow is flagged.
- count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
- Pointer wrap: each pointer goes FIFO_DEPTH-1 -> 0 by explicit compare. The design does not rely on binary rollover.
- FWFT=0 read path:
  - On read accept: data_out <= mem[rd_ptr] and rd_ptr advances. rd_valid=1 for exactly the next cycle (1-cycle latency).
  - Otherwise data_out holds its value and rd_valid=0.
- FWFT=1 read path:
  - data_out = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en pops the head; the next word is visible in the same cycle as the pop edge completes.
  - A word written into an empty FIFO appears on data_out one cycle after the write edge.
- flush (synchronous) has priority over wr_en and rd_en in the same cycle:
  - pointers and count go to 0.
  - wr_ack, overflow and underflow go to 0 next cycle.
  - FWFT=0: rd_valid goes to 0 and data_out holds its value.
- Pulse outputs (wr_ack, overflow, underflow, rd_valid in FWFT=0) are single-cycle per event; they reassert every cycle while the condition repeats.
- Reset asserted mid-burst aborts immediately: all outputs return to reset values without waiting for a clock edge. In-flight requests are lost.
- Assertions required: count <= FIFO_DEPTH; full and empty never both 1; parameter ranges legal at elaboration.

Test Plan:
- Reset, then write 8 words 0x0001..0x0008 (DEPTH=8) -> wr_ack=1 after each write; almostfull=1 after 7th write; full=1 and count=8 after 8th; a 9th write gives overflow=1, wr_ack=0, count stays 8.
- Drain 8 words with FWFT=0 -> data_out = 0x0001..0x0008, each one cycle after its rd_en with rd_valid=1; almostempty=1 at count=1; empty=1 at end; one extra read gives underflow=1.
- DEPTH=5, AF_LEVEL=3, AE_LEVEL=2; run 20 interleaved writes and reads -> pointers wrap 4->0, data order is preserved, flags match their count thresholds on every cycle.
- Full FIFO with wr_en and rd_en both asserted for 4 cycles -> no overflow, count stays 8, outputs are the oldest 4 words, and the last 4 writes are stored.
- FWFT=1: write 0xA5A5 to an empty FIFO -> data_out=0xA5A5 and rd_valid=1 the next cycle; rd_en pops and the FIFO goes empty; rd_en and wr_en on an empty FIFO give underflow=1 with count=1.
- Tests for flush and reset:
  - With count=6, assert flush together with wr_en -> count=0, empty=1, no wr_ack.
  - Assert rst_n low mid-cycle -> empty=1 and data_out=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// The master modport is the producer/consumer side and the slave modport is the FIFO.
interface fifo_sync_param_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
);
  logic [FIFO_WIDTH-1:0]              data_in;
  logic                               wr_en;
  logic                               rd_en;
  logic                               flush;
  logic [FIFO_WIDTH-1:0]              data_out;
  logic                               rd_valid;
  logic                               wr_ack;
  logic                               overflow;
  logic                               underflow;
  logic                               full;
  logic                               empty;
  logic                               almostfull;
  logic                               almostempty;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    count;

  modport master (
    output data_in, wr_en, rd_en, flush,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en, flush,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO: any depth (including non power of two),
// almost-full/empty thresholds, optional first-word-fall-through, flush and occupancy count.
module fifo_sync_param #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter bit          FWFT       = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  fifo_sync_param_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  if (FIFO_WIDTH == 0 || FIFO_DEPTH < 2 ||
      AF_LEVEL == 0 || AF_LEVEL > FIFO_DEPTH - 1 ||
      AE_LEVEL == 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_param_check
    $error("fifo_sync_param: illegal parameter combination");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  full;
  logic                  empty;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rd_go;
  logic                  wr_go;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_accept = bus.rd_en && !empty;
  assign wr_accept = bus.wr_en && (!full || rd_accept);
  assign rd_go     = rd_accept && !bus.flush;
  assign wr_go     = wr_accept && !bus.flush;

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (cnt >= AF_C) && !full;
  assign bus.almostempty = !empty && (cnt <= AE_C);
  assign bus.count       = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.wr_ack    <= wr_accept;
      bus.overflow  <= bus.wr_en && !wr_accept;
      bus.underflow <= bus.rd_en && !rd_accept;
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is shown directly; forced to zero when empty so reset reads back 0.
    assign bus.data_out = empty ? '0 : mem[rd_ptr];
    assign bus.rd_valid = !empty;
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bus.data_out <= '0;
        bus.rd_valid <= 1'b0;
      end else begin
        bus.rd_valid <= rd_go;
        if (rd_go) begin
          bus.data_out <= mem[rd_ptr];
        end
      end
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) cnt <= DEPTH_C);
  a_full_empty  : assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

endmodule
